aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
- Sequencer for the masked 128-bit AES round datapath: one round per LATENCY cycles, NROUNDS rounds, then a cleaning pass.
- Drives state/key register enables, the init-load select, the unmasked round constant (masked downstream by a constant-sharing block), the last-round select and cleaning_on.
- Exposes a valid/ready handshake on input and output so the core can sit behind a block-level wrapper.

Parameters:
- LATENCY, 4, pipeline depth of one round datapath in cycles (>=1).
- NROUNDS, 10, number of AES rounds (AES-128); 1..10.

Ports:
- clk  in  1  clock, all flops rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key shares present on datapath inputs
- in_ready  out  1  controller can accept a block
- out_valid  out  1  ciphertext shares valid in state register
- out_ready  in  1  consumer accepts ciphertext
- load_init  out  1  state/key registers select external input (pulse on accept)
- en_state  out  1  state and key register capture enable
- rcon  out  8  unmasked round constant for current round
- last_round  out  1  final round: state register takes post-ShiftRows output (MixColumns bypass)
- cleaning_on  out  1  zero key input to key-schedule pipeline
- rnd_valid  out  1  randomness consumed this cycle; high whenever datapath runs
- round_idx  out  4  current round number, 0 when idle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, round_idx=0, lat_cnt=0; outputs in_ready=1, all others 0, rcon=8'h00. Reset mid-operation aborts immediately; no partial output.
- States: IDLE, ROUND, CLEAN, DONE.
- IDLE: in_ready=1. Accept when in_valid&in_ready: load_init=1 and en_state=1 combinationally in that cycle; next state ROUND, round_idx=1, lat_cnt=0.
- ROUND: rnd_valid=1; rcon=RCON[round_idx] held for whole round (01,02,04,08,10,20,40,80,1B,36); last_round=(round_idx==NROUNDS). lat_cnt counts 0..LATENCY-1. en_state=1 only at lat_cnt==LATENCY-1. At that cycle: round_idx<NROUNDS -> round_idx+1, lat_cnt=0; else -> CLEAN, lat_cnt=0.
- CLEAN: cleaning_on=1, rnd_valid=1, en_state=0, rcon=00, for exactly LATENCY cycles; then DONE.
- DONE: out_valid=1, round_idx=0, held until out_ready; on out_valid&out_ready -> IDLE. in_ready=0 in DONE (no same-cycle restart; one idle cycle minimum between blocks).
- in_valid outside IDLE ignored; out_ready outside DONE ignored.
- Latency: accept at cycle 0 -> out_valid first high at cycle 1+(NROUNDS+1)*LATENCY (45 for defaults).
- LATENCY=1: lat_cnt width 1, capture every ROUND cycle, CLEAN one cycle.
- Counter widths: lat_cnt $clog2(LATENCY) min 1 bit; round_idx 4 bits; no wrap possible as transitions bound counts.
- All outputs are functions of registered state/counters only, except load_init/en_state in IDLE (depend on in_valid).

Optional Feature:
- Macro AES_CTRL_CLEAN_EN.
- Defined: CLEAN state present as above.
- Undefined: CLEAN removed; last ROUND capture -> DONE directly; cleaning_on tied 0; latency 1+NROUNDS*LATENCY (41 for defaults).

Test Plan:
- Reset: rst_n low mid-ROUND (round 5) -> next edge-independent: in_ready=1, busy=0, en_state=0, round_idx=0, rcon=00.
- Single block defaults: in_valid pulse at cycle 0 -> load_init=1 cycle 0; en_state high at cycles 4,8,...,40; rcon 01 during cycles 1-4, 36 during 37-40; last_round only cycles 37-40; cleaning_on cycles 41-44; out_valid cycle 45.
- Output backpressure: out_ready=0 for 7 cycles after out_valid -> out_valid held, no en_state, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- Input during busy: in_valid held high from cycle 0 -> exactly one accept until return to IDLE; second accept one cycle after output handshake.
- LATENCY=1, NROUNDS=10 -> en_state every cycle 1-10, cleaning_on cycle 11, out_valid cycle 12.
- AES_CTRL_CLEAN_EN undefined, defaults -> cleaning_on never 1, out_valid at cycle 41.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the masked AES-128 datapath; accept -> out_valid in 1+(NROUNDS+1)*LATENCY cycles (1+NROUNDS*LATENCY without cleaning).
// Backpressure: in_ready only in IDLE; DONE holds out_valid until out_ready. `AES_CTRL_CLEAN_EN enables the cleaning pass.
module aes_round_ctrl #(
   parameter int LATENCY = 4,
   parameter int NROUNDS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       load_init,
   output logic       en_state,
   output logic [7:0] rcon,
   output logic       last_round,
   output logic       cleaning_on,
   output logic       rnd_valid,
   output logic [3:0] round_idx,
   output logic       busy
);

   localparam int LCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      CLEAN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       round_nxt;
   logic [LCW-1:0]   lat_cnt, lat_nxt;
   logic             lat_last;
   logic             round_last;

   assign lat_last   = (lat_cnt == LCW'(LATENCY - 1));
   assign round_last = (round_idx == 4'(NROUNDS));

   function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon_lut = 8'h01;
         4'd2:    rcon_lut = 8'h02;
         4'd3:    rcon_lut = 8'h04;
         4'd4:    rcon_lut = 8'h08;
         4'd5:    rcon_lut = 8'h10;
         4'd6:    rcon_lut = 8'h20;
         4'd7:    rcon_lut = 8'h40;
         4'd8:    rcon_lut = 8'h80;
         4'd9:    rcon_lut = 8'h1B;
         4'd10:   rcon_lut = 8'h36;
         default: rcon_lut = 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         round_idx <= 4'd0;
         lat_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         round_idx <= round_nxt;
         lat_cnt   <= lat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      round_nxt = round_idx;
      lat_nxt   = lat_cnt;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = ROUND;
               round_nxt = 4'd1;
               lat_nxt   = '0;
            end
         end
         ROUND: begin
            if (lat_last) begin
               lat_nxt = '0;
               if (round_last) begin
                  round_nxt = 4'd0;
`ifdef AES_CTRL_CLEAN_EN
                  state_nxt = CLEAN;
`else
                  state_nxt = DONE;
`endif
               end else begin
                  round_nxt = round_idx + 4'd1;
               end
            end else begin
               lat_nxt = lat_cnt + 1'b1;
            end
         end
`ifdef AES_CTRL_CLEAN_EN
         // Flush the key-schedule pipeline with zero key for one full round depth.
         CLEAN: begin
            if (lat_last) begin
               state_nxt = DONE;
               lat_nxt   = '0;
            end else begin
               lat_nxt = lat_cnt + 1'b1;
            end
         end
`endif
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      load_init   = 1'b0;
      en_state    = 1'b0;
      rcon        = 8'h00;
      last_round  = 1'b0;
      cleaning_on = 1'b0;
      rnd_valid   = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            in_ready  = 1'b1;
            load_init = in_valid;
            en_state  = in_valid;
         end
         ROUND: begin
            busy       = 1'b1;
            rnd_valid  = 1'b1;
            rcon       = rcon_lut(round_idx);
            last_round = round_last;
            en_state   = lat_last;
         end
`ifdef AES_CTRL_CLEAN_EN
         CLEAN: begin
            busy        = 1'b1;
            rnd_valid   = 1'b1;
            cleaning_on = 1'b1;
         end
`endif
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
